// File: rtl/alu_result_if.sv
// Ready/valid result stream plus pop-driven reader port of the ALU result sink.
// Handshake: a result transfers on a rising edge where i_VALID and o_READY are both 1; i_DATA must stay stable while i_VALID waits for o_READY.
interface alu_result_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             i_VALID;
  logic [WIDTH-1:0] i_DATA;
  logic             o_READY;
  logic             i_HOLD;
  logic             i_POP;
  logic [WIDTH-1:0] o_DATA;
  logic             o_EMPTY;
  logic             o_FULL;
  logic [LW-1:0]    o_LEVEL;
  logic [CNTW-1:0]  o_COUNT;
  logic             o_UNDERFLOW;

  modport master (
    output i_VALID, i_DATA, i_HOLD, i_POP,
    input  o_READY, o_DATA, o_EMPTY, o_FULL, o_LEVEL, o_COUNT, o_UNDERFLOW
  );

  modport slave (
    input  i_VALID, i_DATA, i_HOLD, i_POP,
    output o_READY, o_DATA, o_EMPTY, o_FULL, o_LEVEL, o_COUNT, o_UNDERFLOW
  );
endinterface

// File: rtl/alu_result_sink.sv
// Consumer end of the ALU result stream: FIFO buffer with back-pressure,
// saturating accepted-result counter and sticky underflow flag.
module alu_result_sink #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input logic        i_CLK,
  input logic        i_RSTn,
  alu_result_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;
  logic             underflow;
  logic             empty;
  logic             full;
  logic             ready;
  logic             push;
  logic             pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign ready = i_RSTn && !full && !bus.i_HOLD;
  assign push  = bus.i_VALID && ready;
  assign pop   = bus.i_POP && !empty;

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= bus.i_DATA;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      if (push && (count != {CNTW{1'b1}})) count <= count + 1'b1;
      if (bus.i_POP && empty) underflow <= 1'b1;
    end
  end

  assign bus.o_READY     = ready;
  assign bus.o_DATA      = mem[rd_ptr[AW-1:0]];
  assign bus.o_EMPTY     = empty;
  assign bus.o_FULL      = full;
  assign bus.o_LEVEL     = wr_ptr - rd_ptr;
  assign bus.o_COUNT     = count;
  assign bus.o_UNDERFLOW = underflow;
endmodule
